// File: rtl/sram_pkg.sv
// Shared types and constants for the half-word SRAM data-memory controller.
package sram_pkg;

  localparam int unsigned SRAM_AW       = 18;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned CPU_DW        = 32;
  localparam int unsigned WORD_W        = SRAM_AW - 1;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned BASE_ADDR_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Processor byte address to SRAM word index; wraps silently outside the window.
  function automatic logic [WORD_W-1:0] word_of(input logic [CPU_DW-1:0] addr,
                                                input logic [CPU_DW-1:0] base);
    return WORD_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_if.sv
// MEM-stage request/response and external SRAM pins bundled for the controller.
interface sram_if;
  import sram_pkg::*;

  logic              wr_en;
  logic              rd_en;
  logic [CPU_DW-1:0] address;
  logic [CPU_DW-1:0] write_data;
  logic [CPU_DW-1:0] read_data;
  logic              ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic              sram_we_n;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Clearable up-counter timing each half-word access; flags its final cycle.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last_c = (r_count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Data-memory controller: splits each 32-bit MEM-stage access into two
// half-word SRAM accesses and holds ready low until the word is complete.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  sram_if.slave bus
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_is_wr;
  logic                w_is_wr_nxt;
  logic [SRAM_AW-1:0]  r_sram_addr;
  logic [SRAM_AW-1:0]  w_sram_addr_nxt;
  logic [SRAM_DW-1:0]  r_dq_out;
  logic [SRAM_DW-1:0]  w_dq_out_nxt;
  logic                r_dq_oe;
  logic                w_dq_oe_nxt;
  logic                r_we_n;
  logic                w_we_n_nxt;
  logic [CPU_DW-1:0]   r_read_data;
  logic [CPU_DW-1:0]   w_read_data_nxt;
  logic                w_req;
  logic                w_ready_c;
  logic                w_cnt_run;
  logic                w_cnt_clr;
  logic                w_last_c;
  logic [WORD_W-1:0]   w_word;

  assign w_req     = bus.rd_en | bus.wr_en;
  assign w_word    = word_of(bus.address, CPU_DW'(BASE_ADDR));
  // Counter restarts at zero on every half-word boundary.
  assign w_cnt_clr = ~w_cnt_run | w_last_c;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_run),
    .o_last_c (w_last_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_is_wr     <= 1'b0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_read_data <= '0;
    end else begin
      r_is_wr     <= w_is_wr_nxt;
      r_sram_addr <= w_sram_addr_nxt;
      r_dq_out    <= w_dq_out_nxt;
      r_dq_oe     <= w_dq_oe_nxt;
      r_we_n      <= w_we_n_nxt;
      r_read_data <= w_read_data_nxt;
    end
  end

  // Pin values are computed one edge ahead so every SRAM output is a flop.
  always_comb begin
    w_state_nxt     = r_state;
    w_is_wr_nxt     = r_is_wr;
    w_sram_addr_nxt = r_sram_addr;
    w_dq_out_nxt    = r_dq_out;
    w_dq_oe_nxt     = r_dq_oe;
    w_we_n_nxt      = r_we_n;
    w_read_data_nxt = r_read_data;
    w_ready_c       = 1'b0;
    w_cnt_run       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_ready_c = ~w_req;
        if (w_req) begin
          w_state_nxt     = LO;
          w_is_wr_nxt     = bus.wr_en;
          w_sram_addr_nxt = {w_word, 1'b0};
          w_dq_oe_nxt     = bus.wr_en;
          w_we_n_nxt      = ~bus.wr_en;
          if (bus.wr_en) begin
            w_dq_out_nxt = bus.write_data[SRAM_DW-1:0];
          end
        end
      end
      LO: begin
        w_cnt_run = 1'b1;
        if (w_last_c) begin
          w_state_nxt     = HI;
          w_sram_addr_nxt = {r_sram_addr[SRAM_AW-1:1], 1'b1};
          if (r_is_wr) begin
            w_dq_out_nxt = bus.write_data[CPU_DW-1:SRAM_DW];
          end else begin
            w_read_data_nxt[SRAM_DW-1:0] = bus.sram_dq_in;
          end
        end
      end
      HI: begin
        w_cnt_run = 1'b1;
        if (w_last_c) begin
          w_state_nxt = DONE;
          w_dq_oe_nxt = 1'b0;
          w_we_n_nxt  = 1'b1;
          if (!r_is_wr) begin
            w_read_data_nxt[CPU_DW-1:SRAM_DW] = bus.sram_dq_in;
          end
        end
      end
      DONE: begin
        w_ready_c   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ready       = w_ready_c;
  assign bus.read_data   = r_read_data;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: two instances (WAIT_CYCLES 1 and 2), each
// with a half-word SRAM model and a word-level reference memory.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int unsigned BASE   = 1024;
  localparam int          N_RAND = 40;

  typedef struct {
    bit          idle;
    int          n;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    bit          pins;
    bit          abort;
  } op_t;

  typedef struct {
    int          stall;
    logic [31:0] rdata;
    bit          wchk;
    logic [16:0] word;
    logic [31:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic op_t mk_acc(input bit wr, input bit rd, input logic [31:0] addr,
                                 input logic [31:0] data, input bit pins, input bit abort);
    op_t o;
    o.idle = 1'b0; o.n = 0; o.wr = wr; o.rd = rd; o.addr = addr; o.data = data;
    o.pins = pins; o.abort = abort;
    return o;
  endfunction

  function automatic op_t mk_idle(input int n);
    op_t o;
    o.idle = 1'b1; o.n = n; o.wr = 1'b0; o.rd = 1'b0; o.addr = '0; o.data = '0;
    o.pins = 1'b0; o.abort = 1'b0;
    return o;
  endfunction

  // Word index within a 2^17-word space, wrapping around.
  function automatic logic [16:0] key_of(input logic [31:0] addr);
    logic [31:0] d;
    d = ((addr - 32'(BASE)) / 32'd4) % 32'd131072;
    return 17'(d);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int WI    = g + 1;
    localparam int STALL = 2 * WI + 1;

    logic        rst;
    logic        done;
    logic [15:0] sram [0:262143];
    exp_t        exq[$];
    int          stall_cnt = 0;

    sram_if u_if ();

    sram_ctrl #(
      .WAIT_CYCLES(WI),
      .BASE_ADDR  (BASE)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if)
    );

    assign u_if.sram_dq_in = sram[u_if.sram_addr];

    always @(posedge clk) begin
      if (!u_if.sram_we_n && u_if.sram_dq_oe) sram[u_if.sram_addr] <= u_if.sram_dq_out;
    end

    // Completion = ready returning high after a stall; an access cut by reset is dropped.
    always @(negedge clk) begin : p_mon
      exp_t e;
      if (!rst) begin
        stall_cnt = 0;
      end else if (!u_if.ready) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (exq.size() == 0) begin
          chk($sformatf("W%0d unexpected_completion", WI), 32'(stall_cnt), 32'd0);
        end else begin
          e = exq.pop_front();
          chk($sformatf("W%0d stall", WI), 32'(stall_cnt), 32'(e.stall));
          chk($sformatf("W%0d read_data", WI), u_if.read_data, e.rdata);
          if (e.wchk) begin
            chk($sformatf("W%0d sram_lo w%0h", WI, e.word), 32'(sram[{e.word, 1'b0}]),
                32'(e.wdata[15:0]));
            chk($sformatf("W%0d sram_hi w%0h", WI, e.word), 32'(sram[{e.word, 1'b1}]),
                32'(e.wdata[31:16]));
          end
        end
        stall_cnt = 0;
      end
    end

    initial begin : p_stim
      op_t         ops[$];
      op_t         o;
      exp_t        e;
      logic [31:0] ref_mem [int];
      logic [31:0] last_rd;
      bit          written [64];
      logic [16:0] k;
      int          w;
      int          t;
      bit          seen;
      bit          hi;

      rst = 1'b0; done = 1'b0; last_rd = '0;
      u_if.wr_en = 1'b0; u_if.rd_en = 1'b0; u_if.address = '0; u_if.write_data = '0;

      ops.push_back(mk_idle(10));
      ops.push_back(mk_acc(1, 0, 32'd1024, 32'hDEADBEEF, 1, 0));
      ops.push_back(mk_acc(0, 1, 32'd1024, 32'h0, 0, 0));
      ops.push_back(mk_idle(3));
      ops.push_back(mk_acc(1, 0, 32'd1032, 32'h12345678, 1, 0));
      ops.push_back(mk_acc(0, 1, 32'd1032, 32'h0, 0, 0));
      ops.push_back(mk_acc(1, 1, 32'd1036, 32'hCAFEF00D, 1, 0));
      ops.push_back(mk_acc(0, 1, 32'd1036, 32'h0, 0, 0));
      ops.push_back(mk_acc(1, 0, 32'd1028, 32'hA5A55A5A, 0, 0));
      ops.push_back(mk_idle(1));
      ops.push_back(mk_acc(0, 1, 32'd1024, 32'h0, 0, 0));
      ops.push_back(mk_acc(0, 1, 32'd1028, 32'h0, 0, 0));
      ops.push_back(mk_acc(1, 0, 32'd1020, 32'h0BADC0DE, 1, 0));
      ops.push_back(mk_acc(0, 1, 32'd1020, 32'h0, 0, 0));
      ops.push_back(mk_acc(1, 0, 32'h0008_0408, 32'h11112222, 0, 0));
      ops.push_back(mk_acc(0, 1, 32'd1032, 32'h0, 0, 0));
      ops.push_back(mk_acc(1, 0, 32'd1424, 32'h77778888, 0, 1));
      ops.push_back(mk_acc(0, 1, 32'd1424, 32'h0, 0, 0));
      ops.push_back(mk_idle(2));
      for (int r = 0; r < N_RAND; r++) begin
        w = int'($urandom_range(63, 0));
        t = int'($urandom_range(3, 0));
        if (t >= 2 && written[w]) begin
          ops.push_back(mk_acc(0, 1, 32'(BASE) + 32'(4 * w), 32'h0, 0, 0));
        end else begin
          ops.push_back(mk_acc(1, t == 1, 32'(BASE) + 32'(4 * w), $urandom, 0, 0));
          written[w] = 1'b1;
        end
        if ($urandom_range(3, 0) == 0) ops.push_back(mk_idle(int'($urandom_range(2, 1))));
      end
      ops.push_back(mk_idle(3));

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      foreach (ops[i]) begin
        o = ops[i];
        @(posedge clk);
        #1;
        if (o.idle) begin
          u_if.wr_en = 1'b0;
          u_if.rd_en = 1'b0;
          repeat (o.n) begin
            @(negedge clk);
            chk($sformatf("W%0d idle ready", WI), 32'(u_if.ready), 32'd1);
            chk($sformatf("W%0d idle we_n", WI), 32'(u_if.sram_we_n), 32'd1);
            chk($sformatf("W%0d idle oe", WI), 32'(u_if.sram_dq_oe), 32'd0);
            chk($sformatf("W%0d idle read_data", WI), u_if.read_data, last_rd);
          end
        end else begin
          u_if.wr_en      = o.wr;
          u_if.rd_en      = o.rd;
          u_if.address    = o.addr;
          u_if.write_data = o.data;
          k = key_of(o.addr);
          if (o.abort) last_rd = '0;
          e.stall = STALL;
          e.word  = k;
          e.wdata = o.data;
          e.wchk  = o.wr;
          if (o.wr) begin
            ref_mem[int'(k)] = o.data;
          end else begin
            last_rd = ref_mem.exists(int'(k)) ? ref_mem[int'(k)] : 32'h0;
          end
          e.rdata = last_rd;
          exq.push_back(e);

          if (o.abort) begin
            repeat (WI + 1) @(posedge clk);
            #1 rst = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
            @(negedge clk);
            chk($sformatf("W%0d rst we_n", WI), 32'(u_if.sram_we_n), 32'd1);
            chk($sformatf("W%0d rst oe", WI), 32'(u_if.sram_dq_oe), 32'd0);
            chk($sformatf("W%0d rst read_data", WI), u_if.read_data, 32'd0);
            chk($sformatf("W%0d rst sram_addr", WI), 32'(u_if.sram_addr), 32'd0);
            chk($sformatf("W%0d rst dq_out", WI), 32'(u_if.sram_dq_out), 32'd0);
            chk($sformatf("W%0d rst ready", WI), 32'(u_if.ready), 32'd0);
          end

          seen = 1'b0;
          for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            if (o.pins) begin
              if (c >= 1 && c <= 2 * WI) begin
                hi = (c > WI);
                chk($sformatf("W%0d sram_addr c%0d", WI, c), 32'(u_if.sram_addr), 32'({k, hi}));
                chk($sformatf("W%0d dq_out c%0d", WI, c), 32'(u_if.sram_dq_out),
                    hi ? 32'(o.data[31:16]) : 32'(o.data[15:0]));
                chk($sformatf("W%0d we_n c%0d", WI, c), 32'(u_if.sram_we_n), 32'd0);
                chk($sformatf("W%0d oe c%0d", WI, c), 32'(u_if.sram_dq_oe), 32'd1);
              end
              if (c == 2 * WI + 1) begin
                chk($sformatf("W%0d done we_n", WI), 32'(u_if.sram_we_n), 32'd1);
                chk($sformatf("W%0d done oe", WI), 32'(u_if.sram_dq_oe), 32'd0);
              end
              chk($sformatf("W%0d ready c%0d", WI, c), 32'(u_if.ready), 32'(c == 2 * WI + 1));
            end
            if (u_if.ready) seen = 1'b1;
          end
          chk($sformatf("W%0d access_completes", WI), 32'(seen), 32'd1);
        end
      end

      repeat (4) @(negedge clk);
      chk($sformatf("W%0d scoreboard_drained", WI), 32'(exq.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    wait (g_dut[0].done && g_dut[1].done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
